// File: rtl/hidden_cpu_instr_sequencer.sv
// Program buffer and replay engine feeding the HiddenCPU instruction input.
// Words are loaded while idle, then replayed one per clock with support for
// hold, abort and optional wrap-around looping.
module hidden_cpu_instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int IW    = 6,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    input  logic          start,
    input  logic          clear,
    input  logic          abort,
    input  logic          hold,
    input  logic          loop_en,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [PW-1:0] pc,
    output logic [PW:0]   count,
    output logic          done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [PW:0] L_DEPTH = (PW+1)'(DEPTH);

    state_t        r_state;
    logic [IW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_pc;
    logic [PW:0]   r_count;
    logic [IW-1:0] r_instr;
    logic          r_valid;
    logic          r_done;

    logic          w_load_ready;
    logic          w_load_accept;
    logic          w_last;
    logic [PW-1:0] w_pc_inc;

    // Loading is only possible while idle, not full, and no higher-priority command is present.
    assign w_load_ready  = (r_state == S_IDLE) && (r_count < L_DEPTH) && !start && !clear;
    assign w_load_accept = load_valid && w_load_ready;

    // The entry on instr_out is the final one of the program.
    assign w_last   = ({1'b0, r_pc} == (r_count - (PW+1)'(1)));
    // Only used when not on the last entry, so it can never wrap past DEPTH-1.
    assign w_pc_inc = r_pc + PW'(1);

    // Program storage: written only by accepted load words.
    always_ff @(posedge clk) begin
        if (w_load_accept) begin
            r_mem[r_count[PW-1:0]] <= load_data;
        end
    end

    // Control FSM with registered replay outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_count <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear) begin
                        r_count <= '0;
                    end else if (start && (r_count != '0)) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_instr <= r_mem[0];
                        r_valid <= 1'b1;
                    end else if (w_load_accept) begin
                        r_count <= r_count + (PW+1)'(1);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_pc    <= '0;
                        r_instr <= '0;
                        r_valid <= 1'b0;
                    end else if (hold) begin
                        r_state <= S_RUN;
                    end else if (!w_last) begin
                        r_pc    <= w_pc_inc;
                        r_instr <= r_mem[w_pc_inc];
                    end else if (loop_en) begin
                        r_pc    <= '0;
                        r_instr <= r_mem[0];
                    end else begin
                        r_state <= S_IDLE;
                        r_pc    <= '0;
                        r_instr <= '0;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign load_ready  = w_load_ready;
    assign instr_out   = r_instr;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign count       = r_count;
    assign done        = r_done;

endmodule

// File: doc/hidden_cpu_instr_sequencer.md
# hidden_cpu_instr_sequencer

Upstream instruction source for the HiddenCPU core. It buffers a short program of 6-bit instructions loaded over a valid/ready handshake, then replays them one per clock onto the core's 6-bit instruction input. It supports hold, abort and optional looping, so the core can run from on-chip program storage instead of live pin stimulus.

## Interface
- DEPTH, 16: program buffer entries; power of two, 2..32.
- IW, 6: instruction width; matches the core's instruction field.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  program word offered.
- load_data  in  IW  program word.
- load_ready  out  1  combinational: state==IDLE && count<DEPTH && !start && !clear.
- start  in  1  begin replay; sampled in IDLE only.
- clear  in  1  empty the buffer; sampled in IDLE only.
- abort  in  1  stop replay; sampled in RUN only.
- hold  in  1  freeze replay (pc and instr_out) while high in RUN.
- loop_en  in  1  wrap to entry 0 after last entry instead of finishing.
- instr_out  out  IW  registered instruction to core; 0 (NOP) whenever instr_valid=0.
- instr_valid  out  1  registered; high in RUN.
- pc  out  log2(DEPTH)  registered index of the entry on instr_out.
- count  out  log2(DEPTH)+1  registered number of stored entries.
- done  out  1  registered one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN. Storage: DEPTH x IW registers, written only in IDLE.
- IDLE priority per edge: clear > start > load.
  - clear: count←0. Storage contents are don't-care.
  - start with count≠0: state←RUN, pc←0, instr_out←mem[0], instr_valid←1.
  - start with count==0: ignored; stays IDLE, no done pulse.
  - load (load_valid && load_ready): mem[count]←load_data, count←count+1.
  - When count==DEPTH, load_ready=0 and offered words are not consumed.
- RUN per edge, with priority abort > hold > advance:
  - abort: state←IDLE, instr_valid←0, instr_out←0, pc←0. No done pulse. count is preserved.
  - hold: all registers unchanged. instr_out keeps the current instruction with instr_valid=1.
  - advance, pc<count-1: pc←pc+1, instr_out←mem[pc+1].
  - advance, pc==count-1, loop_en=1: pc←0, instr_out←mem[0].
  - advance, pc==count-1, loop_en=0: state←IDLE, instr_valid←0, instr_out←0, pc←0, done←1 for one cycle.
- loop_en is sampled only at the last-entry edge. Changing it mid-run affects only the next wrap decision.
- start, clear and load_valid are ignored in RUN. abort and hold are ignored in IDLE.
- The program is retained after a run. start may be reissued with no reload.
- pc arithmetic is unsigned. With count==DEPTH, the wrap from DEPTH-1 goes to 0 explicitly and never relies on overflow.

## Timing
- Reset (rst high at edge) sets state=IDLE, count=0, pc=0, instr_out=0, instr_valid=0, done=0. Reset wins over every other input and aborts RUN mid-program with no done pulse.
- Load throughput: 1 word per cycle; zero-wait while not full.
- Start latency: start sampled at edge N puts mem[0] on instr_out with instr_valid=1 in the cycle after edge N.
- Replay: one instruction per cycle. With no hold, an n-entry program occupies exactly n cycles of instr_valid=1.
- Done timing: done is high in the cycle after the last entry's valid cycle, concurrent with instr_valid=0. A new start is accepted on that same cycle.
- Loop timing: no bubble between mem[count-1] and mem[0].

## Test plan
- Reset then load 3 words 0x05, 0x2A, 0x3F, then pulse start. Required: instr_out = 05, 2A, 3F on 3 consecutive cycles with instr_valid=1, pc=0,1,2. Then instr_valid=0, instr_out=0, and done=1 for exactly one cycle.
- Hold valid load words continuously with DEPTH=16. Required: exactly 16 accepted, count=16, load_ready=0 afterward. Run then replays all 16 and pc wraps back to 0 at finish.
- With loop_en=1 and 2-entry program {0x11,0x22}, run 7 cycles. Required: 11,22,11,22,11,22,11 with no gap and no done. Assert abort: next cycle instr_valid=0, count still 2, done never pulses.
- Assert hold for 3 cycles while pc=1 of {0x01,0x02,0x03}. Required: instr_out=02 for 4 cycles total, then 03, then done.
- Apply start with count=0: stays IDLE with no done. Assert clear and start together with count=4: count←0 and no run begins. Assert start and load_valid together: start wins, word not consumed, load_ready=0.
- Assert rst in the middle of an 8-entry run at pc=4. Required: next cycle all outputs are at reset values, count=0, and no done pulse.
